image_proc_arbiter: RTL and testbench
=====================================

# image_proc_arbiter

Shares the single image-processing core between the two slave requesters, slv0 and slv1. It grants the core to one requester for a whole frame and latches that frame's mode and processing value into the core's configuration inputs. It releases the grant on an end-of-frame code or on an idle timeout, and rotates priority round-robin. It sits between the slave ports and the core's input stream; master-side outputs are untouched.

## Interface
Parameters:
- DATA_WIDTH, 32, slave/core data bus width
- COLOR_SIZE, 8, processing-value width
- IDLE_TIMEOUT, 16, consecutive granted-idle cycles that force release (≥2)
- CNT_WIDTH, 16, word counter width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- slv0_mode  in  2  requester 0 frame mode; 2'b11 = end of frame
- slv0_data_valid  in  1  requester 0 word valid
- slv0_proc_val  in  COLOR_SIZE  requester 0 processing value
- slv0_data  in  DATA_WIDTH  requester 0 data word
- slv0_ready  out  1  requester 0 may transfer
- slv1_mode / slv1_data_valid / slv1_proc_val / slv1_data / slv1_ready: same as slv0, for requester 1
- core_mode  out  2  latched mode of granted frame
- core_proc_val  out  COLOR_SIZE  latched processing value
- core_data  out  DATA_WIDTH  granted requester's data word
- core_data_valid  out  1  word valid toward core
- core_ready  in  1  core accepts word
- grant  out  2  one-hot owner (01 = slv0, 10 = slv1, 00 = none)
- busy  out  1  a grant is active
- word_cnt  out  CNT_WIDTH  words transferred in the current frame, saturating

## Operation
- A request is slvN_data_valid=1 with slvN_mode≠2'b11.
- States:
  - IDLE: grant=00; both ready=0; core_data_valid=0.
    - One request → GNTn.
    - Both requests → the requester other than last_grant wins.
    - On entry to GNTn: latch slvN_mode into core_mode and slvN_proc_val into core_proc_val; clear word_cnt and idle_cnt; last_grant ← n.
  - GNTn: core_data = slvN_data; core_data_valid = slvN_data_valid; slvN_ready = core_ready; the other requester's ready = 0.
    - Transfer occurs when valid & ready; word_cnt increments, saturating at all-ones.
    - Granted data_valid=0 increments idle_cnt; valid=1 clears it.
- Release from GNTn to IDLE when either:
  - slvN_mode==2'b11 is sampled. That cycle, core_data_valid and slvN_ready are forced to 0, so no word transfers.
  - idle_cnt reaches IDLE_TIMEOUT.
- core_mode and core_proc_val hold their latched values through IDLE until the next grant. Mode/proc_val changes during a grant are ignored.
- The ungranted requester is only stalled (ready=0); its requests are never dropped.
- On reset:
  - state=IDLE, grant=00, busy=0, word_cnt=0, idle_cnt=0
  - core_mode=2'b00, core_proc_val=0, core_data_valid=0, both ready=0
  - last_grant=1, so slv0 wins the first tie.

## Timing
- Grant latency: request sampled in IDLE at edge N → grant/busy/core_mode valid after edge N; first transfer possible in cycle N+1.
- Data path is combinational through the mux: zero added latency; ready and valid pass through within the same cycle.
- End of frame: mode=2'b11 sampled at edge M → IDLE after M. Earliest re-grant is after edge M+1, so there is one dead cycle between frames.
- Timeout: IDLE_TIMEOUT consecutive idle cycles → IDLE after the edge at which idle_cnt==IDLE_TIMEOUT.
- Reset asserted mid-frame: takes effect at the next edge regardless of state. An in-flight word is not transferred (ready=0 after that edge).
- End-of-frame code, valid=1 and core_ready=1 in the same cycle: release wins; the word is not accepted.
- Both requesters are always recomputed from IDLE only; no pre-emption during a grant.

## Test plan
- Single frame: reset, slv0 sends 8 words 0x00000001..0x00000008 with mode=2'b10, proc_val=0x40, core_ready=1, then mode=2'b11. Required: grant=01 one cycle after first valid, 8 words appear on core_data in order, word_cnt=8, core_mode=2'b10 and core_proc_val=0x40 held, IDLE one cycle after the end code.
- Simultaneous request: both requesters valid in the same cycle after reset. Required: slv0 granted first, slv1_ready=0 throughout. After slv0 ends, slv1 is granted exactly 2 cycles after slv0's end code.
- Round-robin: slv0 ends, then both request together. Required: slv1 wins.
- Backpressure: core_ready toggles 1,0,1,0 during a 4-word slv1 frame. Required: slv1_ready mirrors core_ready, each word is held until accepted, word_cnt=4.
- Timeout: slv0 granted, then valid=0 for IDLE_TIMEOUT=16 cycles. Required: busy falls after the 16th idle cycle and slv1's pending request is granted next.
- Reset mid-frame: rst=1 during slv1's 3rd word. Required: next cycle grant=00, ready=0, word_cnt=0, core_mode=2'b00, and slv0 wins the subsequent tie.

Source files
------------

// File: rtl/image_proc_arbiter.sv
// Round-robin arbiter sharing one image-processing core between two slave requesters.
// A grant lasts a whole frame; it ends on an end-of-frame mode code or an idle timeout.
module image_proc_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int COLOR_SIZE   = 8,
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            slv0_mode,
  input  logic                  slv0_data_valid,
  input  logic [COLOR_SIZE-1:0] slv0_proc_val,
  input  logic [DATA_WIDTH-1:0] slv0_data,
  output logic                  slv0_ready,
  input  logic [1:0]            slv1_mode,
  input  logic                  slv1_data_valid,
  input  logic [COLOR_SIZE-1:0] slv1_proc_val,
  input  logic [DATA_WIDTH-1:0] slv1_data,
  output logic                  slv1_ready,
  output logic [1:0]            core_mode,
  output logic [COLOR_SIZE-1:0] core_proc_val,
  output logic [DATA_WIDTH-1:0] core_data,
  output logic                  core_data_valid,
  input  logic                  core_ready,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int         IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [1:0] EOF_CODE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_t;

  state_t              state;
  logic                last_grant;
  logic [IDLE_W-1:0]   idle_cnt;

  logic                req0, req1, start, pick;
  logic                own_valid, own_eof, xfer, timeout_hit;
  logic [1:0]          own_mode;

  assign req0  = slv0_data_valid && (slv0_mode != EOF_CODE);
  assign req1  = slv1_data_valid && (slv1_mode != EOF_CODE);
  assign start = req0 || req1;
  // slv1 takes the grant when it is the only requester, or on a tie when slv0 went last.
  assign pick  = req1 && (!req0 || !last_grant);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    own_valid = 1'b0;
    own_mode  = 2'b00;
    core_data = '0;
    case (state)
      S_GNT0: begin
        own_valid = slv0_data_valid;
        own_mode  = slv0_mode;
        core_data = slv0_data;
      end
      S_GNT1: begin
        own_valid = slv1_data_valid;
        own_mode  = slv1_mode;
        core_data = slv1_data;
      end
      default: ;
    endcase
  end

  // The end-of-frame cycle never carries a word, and a pending reset kills the in-flight word.
  assign own_eof         = (state != S_IDLE) && (own_mode == EOF_CODE);
  assign core_data_valid = own_valid && !own_eof && !rst;
  assign slv0_ready      = (state == S_GNT0) && core_ready && !own_eof && !rst;
  assign slv1_ready      = (state == S_GNT1) && core_ready && !own_eof && !rst;
  assign xfer            = core_data_valid && core_ready;
  assign timeout_hit     = (state != S_IDLE) && !own_valid &&
                           (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      grant         <= 2'b00;
      busy          <= 1'b0;
      word_cnt      <= '0;
      idle_cnt      <= '0;
      core_mode     <= 2'b00;
      core_proc_val <= '0;
      last_grant    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= pick ? S_GNT1 : S_GNT0;
            grant         <= pick ? 2'b10 : 2'b01;
            busy          <= 1'b1;
            core_mode     <= pick ? slv1_mode : slv0_mode;
            core_proc_val <= pick ? slv1_proc_val : slv0_proc_val;
            word_cnt      <= '0;
            idle_cnt      <= '0;
            last_grant    <= pick;
          end
        end
        default: begin
          if (own_eof || timeout_hit) begin
            state <= S_IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
          end else begin
            if (xfer && (word_cnt != '1)) word_cnt <= word_cnt + 1'b1;
            idle_cnt <= own_valid ? '0 : idle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_proc_arbiter.sv
// Scoreboard bench for image_proc_arbiter: a frame-level reference model predicts ownership
// and accepted words; a negedge monitor pops the expected words as the core accepts them.
module tb_image_proc_arbiter;

  localparam int DW      = 32;
  localparam int CS      = 8;
  localparam int TO      = 16;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    s_mode [2];
  logic          s_v    [2];
  logic [CS-1:0] s_pv   [2];
  logic [DW-1:0] s_data [2];
  logic          slv0_ready, slv1_ready;
  logic [1:0]    core_mode;
  logic [CS-1:0] core_proc_val;
  logic [DW-1:0] core_data;
  logic          core_data_valid;
  logic          core_ready;
  logic [1:0]    grant;
  logic          busy;
  logic [CW-1:0] word_cnt;

  image_proc_arbiter #(.DATA_WIDTH(DW), .COLOR_SIZE(CS), .IDLE_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .slv0_mode(s_mode[0]), .slv0_data_valid(s_v[0]), .slv0_proc_val(s_pv[0]),
    .slv0_data(s_data[0]), .slv0_ready(slv0_ready),
    .slv1_mode(s_mode[1]), .slv1_data_valid(s_v[1]), .slv1_proc_val(s_pv[1]),
    .slv1_data(s_data[1]), .slv1_ready(slv1_ready),
    .core_mode(core_mode), .core_proc_val(core_proc_val), .core_data(core_data),
    .core_data_valid(core_data_valid), .core_ready(core_ready),
    .grant(grant), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic [1:0]    mode;
    logic [CS-1:0] pv;
  } xfer_t;

  xfer_t         exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            last_xfer[2];

  // Reference model: who owns the core (-1 = nobody) and what the frame has latched.
  int            m_owner, m_last, m_idle, m_cnt;
  logic [1:0]    m_mode;
  logic [CS-1:0] m_pv;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_of(int n, int k);
    return DW'(n * 32'h1000_0000 + k);
  endfunction

  // Advance the model across one rising edge using the inputs held during the ending cycle.
  function automatic void model_edge();
    bit r0, r1;
    int w, n;
    if (rst) begin
      m_owner = -1; m_last = 1; m_idle = 0; m_cnt = 0; m_mode = 2'b00; m_pv = '0;
      return;
    end
    if (m_owner < 0) begin
      r0 = s_v[0] && (s_mode[0] != 2'b11);
      r1 = s_v[1] && (s_mode[1] != 2'b11);
      w  = -1;
      if (r0 && r1) w = 1 - m_last;
      else if (r0)  w = 0;
      else if (r1)  w = 1;
      if (w >= 0) begin
        m_owner = w; m_last = w; m_mode = s_mode[w]; m_pv = s_pv[w]; m_cnt = 0; m_idle = 0;
      end
    end else begin
      n = m_owner;
      if (s_mode[n] == 2'b11) m_owner = -1;
      else if (s_v[n]) begin
        m_idle = 0;
        if (core_ready && m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_idle++;
        if (m_idle == TO) m_owner = -1;
      end
    end
  endfunction

  // Check the current cycle against the model, queue any accepted word, then cross one edge.
  task automatic step();
    logic [1:0] eg;
    bit         xf[2];
    bit         rdy[2];
    bit         cv;
    xfer_t      e;
    #1;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    check("grant", grant, eg);
    check("busy", busy, m_owner >= 0);
    check("word_cnt", word_cnt, m_cnt);
    check("core_mode", core_mode, m_mode);
    check("core_proc_val", core_proc_val, m_pv);
    cv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = !rst && (m_owner == i) && (s_mode[i] != 2'b11) && core_ready;
      xf[i]  = rdy[i] && s_v[i];
      if (!rst && (m_owner == i) && (s_mode[i] != 2'b11) && s_v[i]) cv = 1'b1;
      if (xf[i]) begin
        e.src = i; e.data = s_data[i]; e.mode = m_mode; e.pv = m_pv;
        exp_q.push_back(e);
      end
    end
    check("slv0_ready", slv0_ready, rdy[0]);
    check("slv1_ready", slv1_ready, rdy[1]);
    check("core_data_valid", core_data_valid, cv);
    last_xfer = xf;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  // Send a frame of `words` words from requester n, waiting for the grant, then the end code.
  task automatic frame(int n, int words, logic [1:0] md, logic [CS-1:0] pv, bit bp);
    int k     = 1;
    int guard = 0;
    bit cr    = 1'b1;
    s_v[n] = 1'b1; s_mode[n] = md; s_pv[n] = pv; s_data[n] = word_of(n, 1);
    while (k <= words && guard < 400) begin
      if (bp) core_ready = cr;
      step();
      if (bp && m_owner == n) cr = !cr;
      if (last_xfer[n]) begin
        k++;
        s_data[n] = word_of(n, k);
      end
      guard++;
    end
    if (k <= words) begin
      n_checks++; n_fail++;
      $display("FAIL frame_budget: requester %0d sent %0d of %0d words", n, k - 1, words);
    end
    core_ready = 1'b1;
    s_mode[n] = 2'b11;
    step();
    s_v[n] = 1'b0; s_mode[n] = 2'b00;
  endtask

  // Monitor: every accepted word must be the next one the model predicted.
  always @(negedge clk) begin : mon
    xfer_t e;
    if (rst === 1'b0 && core_data_valid === 1'b1 && core_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_xfer: got data %0h expected no transfer at %0t", core_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", core_data, e.data);
        check("xfer_src", grant, (e.src == 1) ? 2'b10 : 2'b01);
        check("xfer_mode", core_mode, e.mode);
        check("xfer_pv", core_proc_val, e.pv);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    rst = 1'b1; core_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_mode[i] = 2'b00; s_v[i] = 1'b0; s_pv[i] = '0; s_data[i] = '0;
    end
    @(posedge clk); model_edge(); #2;
    step();
    rst = 1'b0;
    step();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_core_mode", core_mode, 2'b00);

    // Single frame from slv0.
    frame(0, 8, 2'b10, 8'h40, 1'b0);
    check("frame_word_cnt", word_cnt, 8);
    check("frame_busy_after_eof", busy, 1'b0);
    check("frame_core_mode_held", core_mode, 2'b10);
    check("frame_proc_val_held", core_proc_val, 8'h40);
    step();

    // Simultaneous request after reset, then a backpressured slv1 frame.
    rst = 1'b1; step(); rst = 1'b0;
    s_v[1] = 1'b1; s_mode[1] = 2'b01; s_pv[1] = 8'h11; s_data[1] = word_of(1, 1);
    frame(0, 3, 2'b01, 8'h22, 1'b0);
    frame(1, 4, 2'b01, 8'h11, 1'b1);
    check("bp_word_cnt", word_cnt, 4);

    // Round-robin: slv0 alone, then a tie goes to slv1.
    frame(0, 2, 2'b10, 8'h33, 1'b0);
    s_v[0] = 1'b1; s_mode[0] = 2'b10; s_pv[0] = 8'h44; s_data[0] = word_of(0, 1);
    s_v[1] = 1'b1; s_mode[1] = 2'b01; s_pv[1] = 8'h55; s_data[1] = word_of(1, 1);
    step();
    check("rr_tie_grant", grant, 2'b10);
    frame(1, 2, 2'b01, 8'h55, 1'b0);
    frame(0, 2, 2'b10, 8'h44, 1'b0);

    // Saturating word counter.
    frame(0, 20, 2'b01, 8'h07, 1'b0);
    check("sat_word_cnt", word_cnt, CNT_MAX);

    // Idle timeout with slv1 pending.
    s_v[0] = 1'b1; s_mode[0] = 2'b01; s_pv[0] = 8'h66; s_data[0] = word_of(0, 1);
    step();
    s_v[0] = 1'b0;
    s_v[1] = 1'b1; s_mode[1] = 2'b10; s_pv[1] = 8'h77; s_data[1] = word_of(1, 1);
    for (int i = 0; i < TO - 1; i++) step();
    check("to_busy_before", busy, 1'b1);
    step();
    check("to_busy_after", busy, 1'b0);
    step();
    check("to_next_grant", grant, 2'b10);
    frame(1, 2, 2'b10, 8'h77, 1'b0);

    // Reset during slv1's third word.
    s_v[1] = 1'b1; s_mode[1] = 2'b01; s_pv[1] = 8'h88; s_data[1] = word_of(1, 1);
    got = 0;
    for (int g = 0; g < 20 && got < 2; g++) begin
      step();
      if (last_xfer[1]) begin got++; s_data[1] = word_of(1, got + 1); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_ready", slv1_ready, 1'b0);
    check("mid_rst_word_cnt", word_cnt, 0);
    check("mid_rst_core_mode", core_mode, 2'b00);
    s_v[0] = 1'b1; s_mode[0] = 2'b10; s_pv[0] = 8'h99; s_data[0] = word_of(0, 1);
    step();
    check("mid_rst_tie_grant", grant, 2'b01);
    frame(0, 1, 2'b10, 8'h99, 1'b0);
    frame(1, 1, 2'b01, 8'h88, 1'b0);

    // Randomised traffic with idle windows and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(499) == 0);
      core_ready = ($urandom_range(9) < 7);
      for (int i = 0; i < 2; i++) begin
        s_v[i]    = ((c % 150) < 20) ? 1'b0 : ($urandom_range(3) != 0);
        s_mode[i] = ($urandom_range(11) == 0) ? 2'b11 : 2'($urandom_range(2));
        s_pv[i]   = CS'($urandom);
        s_data[i] = DW'($urandom);
      end
      step();
    end

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin s_v[i] = 1'b0; s_mode[i] = 2'b00; end
    for (int i = 0; i < 3; i++) step();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
